// File: rtl/ysyx_bus_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_bus_pkg
// Shared definitions for the read-channel arbiter in front of the AXI4
// master port: FSM state encoding, AXI burst/ID constants and the helper
// that turns an LSU byte mask into an AXI transfer size.
// ---------------------------------------------------------------------------
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] ID_IFU         = 4'd0;
    localparam logic [3:0] ID_LSU         = 4'd1;
    localparam logic [2:0] SIZE_WORD      = 3'd2;

    // log2(popcount(rstrb)). Legal masks are 0x01/0x03/0x0F/0xFF, which give
    // 0/1/2/3; anything else rounds down to the nearest power of two.
    function automatic logic [2:0] rstrb_to_size(input logic [7:0] rstrb);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, rstrb[i]};
        end
        if (cnt >= 4'd8)      return 3'd3;
        else if (cnt >= 4'd4) return 3'd2;
        else if (cnt >= 4'd2) return 3'd1;
        else                  return 3'd0;
    endfunction

endpackage

// File: rtl/ysyx_bus_rd_arb.sv
// ---------------------------------------------------------------------------
// ysyx_bus_rd_arb
// Shares one AXI4 AR/R channel pair between the IFU fetch port and the LSU
// load port. One outstanding single-beat read at a time, round-robin grant,
// completion returned to the winner as a one-cycle valid pulse. A sticky
// watchdog flag rises if the read data never arrives.
//
// Ports
//   clock, reset                 : clock (rising edge), async active-low reset
//   ifu_araddr/ifu_arvalid       : fetch request (held until out_ifu_rvalid)
//   out_ifu_rdata/out_ifu_rvalid : fetch completion
//   lsu_araddr/lsu_arvalid       : load request (held until out_lsu_rvalid)
//   lsu_rstrb                    : load byte mask (0x01/0x03/0x0F/0xFF)
//   out_lsu_rdata/out_lsu_rvalid : load completion
//   out_rerr                     : non-OKAY response, alongside either rvalid
//   out_timeout                  : sticky watchdog flag
//   io_master_ar*                : AXI4 read address channel
//   io_master_r*                 : AXI4 read data channel
// ---------------------------------------------------------------------------
module ysyx_bus_rd_arb
    import ysyx_bus_pkg::*;
#(
    parameter int XLEN    = `YSYX_XLEN,
    parameter int TIMEOUT = 1023
) (
    input  logic            clock,
    input  logic            reset,

    input  logic [XLEN-1:0] ifu_araddr,
    input  logic            ifu_arvalid,
    output logic [XLEN-1:0] out_ifu_rdata,
    output logic            out_ifu_rvalid,

    input  logic [XLEN-1:0] lsu_araddr,
    input  logic            lsu_arvalid,
    input  logic [7:0]      lsu_rstrb,
    output logic [XLEN-1:0] out_lsu_rdata,
    output logic            out_lsu_rvalid,

    output logic            out_rerr,
    output logic            out_timeout,

    output logic [1:0]      io_master_arburst,
    output logic [2:0]      io_master_arsize,
    output logic [7:0]      io_master_arlen,
    output logic [3:0]      io_master_arid,
    output logic [XLEN-1:0] io_master_araddr,
    output logic            io_master_arvalid,
    input  logic            io_master_arready,

    input  logic [3:0]      io_master_rid,
    input  logic            io_master_rlast,
    input  logic [XLEN-1:0] io_master_rdata,
    input  logic [1:0]      io_master_rresp,
    input  logic            io_master_rvalid,
    output logic            io_master_rready
);

    localparam int             CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO    = CW'(TIMEOUT);
    localparam logic [CW-1:0]  TMO_M1 = CW'(TIMEOUT - 1);

    rd_state_e       state_q, state_d;
    logic            last_lsu_q;
    logic            owner_lsu_q;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      size_q;
    logic [3:0]      id_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      rresp_q;
    logic [CW-1:0]   wdog_q;
    logic            timeout_q;

    logic            any_req;
    logic            grant_lsu;
    logic            grant;
    logic [2:0]      lsu_size_raw;
    logic [2:0]      lsu_size;
    logic            ar_fire;
    logic            r_last_fire;

    // Routing is by the latched owner, so the response ID is not needed.
    logic unused_rid;
    assign unused_rid = ^io_master_rid;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on a tie the port that
    // did not win last time goes first.
    // ------------------------------------------------------------------
    assign any_req      = ifu_arvalid | lsu_arvalid;
    assign grant_lsu    = lsu_arvalid & (~ifu_arvalid | ~last_lsu_q);
    assign grant        = (state_q == ST_IDLE) & any_req;
    assign lsu_size_raw = rstrb_to_size(lsu_rstrb);
    assign lsu_size     = ((XLEN == 32) && (lsu_size_raw > SIZE_WORD)) ? SIZE_WORD
                                                                       : lsu_size_raw;

    assign ar_fire     = (state_q == ST_ADDR) & io_master_arready;
    // rready is high exactly in DATA, so a DATA-state rvalid is a handshake.
    assign r_last_fire = (state_q == ST_DATA) & io_master_rvalid & io_master_rlast;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        state_d           = state_q;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        out_ifu_rvalid    = 1'b0;
        out_lsu_rvalid    = 1'b0;
        out_rerr          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                io_master_arvalid = 1'b1;
                if (io_master_arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                io_master_rready = 1'b1;
                if (io_master_rvalid && io_master_rlast) state_d = ST_RESP;
            end
            ST_RESP: begin
                // Requests are not sampled here, so a port still holding
                // arvalid for one more cycle is not granted twice.
                out_ifu_rvalid = ~owner_lsu_q;
                out_lsu_rvalid = owner_lsu_q;
                out_rerr       = |rresp_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, response capture and watchdog
    // ------------------------------------------------------------------
    // NOTE: the request latch and response registers are plain flops, so
    // they are reset along with the control state; the outputs they drive
    // must read 0 out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lsu_q  <= 1'b0;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            id_q        <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (grant) begin
                owner_lsu_q <= grant_lsu;
                last_lsu_q  <= grant_lsu;
                addr_q      <= grant_lsu ? lsu_araddr : ifu_araddr;
                size_q      <= grant_lsu ? lsu_size   : SIZE_WORD;
                id_q        <= grant_lsu ? ID_LSU     : ID_IFU;
            end

            // Non-last beats are accepted and dropped.
            if (r_last_fire) begin
                rdata_q <= io_master_rdata;
                rresp_q <= io_master_rresp;
            end

            if (ar_fire) begin
                wdog_q <= '0;
            end else if ((state_q == ST_DATA) && (wdog_q != TMO)) begin
                wdog_q <= wdog_q + CW'(1);
            end

            // Set on the edge where the counter reaches TIMEOUT so the flag
            // is visible in the same cycle as the saturated count.
            if ((state_q == ST_DATA) && (wdog_q == TMO_M1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // AR fields come only from the latch, so they hold steady through an
    // AR stall even if the requester lets go of its arvalid.
    assign io_master_araddr  = addr_q;
    assign io_master_arsize  = size_q;
    assign io_master_arid    = id_q;
    assign io_master_arlen   = 8'd0;
    assign io_master_arburst = AXI_BURST_INCR;

    assign out_ifu_rdata = rdata_q;
    assign out_lsu_rdata = rdata_q;
    assign out_timeout   = timeout_q;

    generate
        if (XLEN == 32) begin : g_arsize_chk
            a_arsize_word : assert property (@(posedge clock) disable iff (!reset)
                                             io_master_arsize <= SIZE_WORD);
        end
    endgenerate

endmodule

// File: tb/tb_ysyx_bus_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_bus_rd_arb
// Directed bench for ysyx_bus_rd_arb with a small AXI read slave. Each
// request pushes its expected AR fields and completion onto a scoreboard;
// a monitor compares AR handshakes and completion pulses against it.
// ---------------------------------------------------------------------------
module tb_ysyx_bus_rd_arb;
    import ysyx_bus_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [XLEN-1:0] ifu_araddr, lsu_araddr;
    logic            ifu_arvalid, lsu_arvalid;
    logic [7:0]      lsu_rstrb;
    logic [XLEN-1:0] out_ifu_rdata, out_lsu_rdata;
    logic            out_ifu_rvalid, out_lsu_rvalid, out_rerr, out_timeout;
    logic [1:0]      io_master_arburst;
    logic [2:0]      io_master_arsize;
    logic [7:0]      io_master_arlen;
    logic [3:0]      io_master_arid;
    logic [XLEN-1:0] io_master_araddr;
    logic            io_master_arvalid, io_master_arready;
    logic [3:0]      io_master_rid;
    logic            io_master_rlast;
    logic [XLEN-1:0] io_master_rdata;
    logic [1:0]      io_master_rresp;
    logic            io_master_rvalid, io_master_rready;

    always #5 clock = ~clock;

    ysyx_bus_rd_arb #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clock             (clock),
        .reset             (reset),
        .ifu_araddr        (ifu_araddr),
        .ifu_arvalid       (ifu_arvalid),
        .out_ifu_rdata     (out_ifu_rdata),
        .out_ifu_rvalid    (out_ifu_rvalid),
        .lsu_araddr        (lsu_araddr),
        .lsu_arvalid       (lsu_arvalid),
        .lsu_rstrb         (lsu_rstrb),
        .out_lsu_rdata     (out_lsu_rdata),
        .out_lsu_rvalid    (out_lsu_rvalid),
        .out_rerr          (out_rerr),
        .out_timeout       (out_timeout),
        .io_master_arburst (io_master_arburst),
        .io_master_arsize  (io_master_arsize),
        .io_master_arlen   (io_master_arlen),
        .io_master_arid    (io_master_arid),
        .io_master_araddr  (io_master_araddr),
        .io_master_arvalid (io_master_arvalid),
        .io_master_arready (io_master_arready),
        .io_master_rid     (io_master_rid),
        .io_master_rlast   (io_master_rlast),
        .io_master_rdata   (io_master_rdata),
        .io_master_rresp   (io_master_rresp),
        .io_master_rvalid  (io_master_rvalid),
        .io_master_rready  (io_master_rready)
    );

    typedef struct {
        bit          lsu;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  id;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Slave knobs
    int ar_wait = 0;   // negedges arready stays low after arvalid is seen
    int r_wait  = 0;   // idle cycles before the first R beat
    int r_extra = 0;   // non-last beats ahead of the rlast beat
    bit r_never = 0;   // never return data

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit lsu, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] data, input bit err);
        exp_t e;
        e.lsu  = lsu;
        e.addr = addr;
        e.size = size;
        e.id   = lsu ? ID_LSU : ID_IFU;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // which: 0 ifu_rvalid, 1 lsu_rvalid, 2 io_master_arvalid, 3 io_master_rready
    task automatic wait_sig(input int which, output int at);
        logic s;
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            case (which)
                0:       s = out_ifu_rvalid;
                1:       s = out_lsu_rvalid;
                2:       s = io_master_arvalid;
                default: s = io_master_rready;
            endcase
            if (s) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check($sformatf("wait_sig_%0d_expired", which), 64'd0, 64'd1);
    endtask

    // AXI read slave, driven on the falling edge.
    initial begin : slave
        int  ar_cnt, r_cnt, beats;
        bit  in_r;
        io_master_arready = 1'b0;
        io_master_rvalid  = 1'b0;
        io_master_rlast   = 1'b0;
        io_master_rdata   = '0;
        io_master_rresp   = '0;
        io_master_rid     = 4'h5;
        ar_cnt = 0; r_cnt = 0; beats = 0; in_r = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                io_master_arready = 1'b0;
                io_master_rvalid  = 1'b0;
                io_master_rlast   = 1'b0;
                in_r   = 0;
                ar_cnt = 0;
            end else begin
                if (!in_r) begin
                    if (io_master_arready) begin
                        io_master_arready = 1'b0;
                        in_r  = 1;
                        r_cnt = 0;
                        beats = r_extra;
                    end else if (io_master_arvalid) begin
                        if (ar_cnt >= ar_wait) io_master_arready = 1'b1;
                        else                   ar_cnt++;
                    end
                end else if (io_master_rvalid) begin
                    if (io_master_rlast) begin
                        io_master_rvalid = 1'b0;
                        io_master_rlast  = 1'b0;
                        in_r   = 0;
                        ar_cnt = 0;
                    end else begin
                        beats--;
                    end
                end
                if (in_r) begin
                    if (r_never || r_cnt < r_wait) begin
                        io_master_rvalid = 1'b0;
                        io_master_rlast  = 1'b0;
                        if (!r_never) r_cnt++;
                    end else begin
                        io_master_rvalid = 1'b1;
                        if (beats == 0) begin
                            io_master_rlast = 1'b1;
                            io_master_rdata = (sb.size() > 0) ? sb[0].data : 32'h0;
                            io_master_rresp = (sb.size() > 0 && sb[0].err) ? 2'b10 : 2'b00;
                        end else begin
                            io_master_rlast = 1'b0;
                            io_master_rdata = (sb.size() > 0) ? ~sb[0].data : 32'hFFFF_FFFF;
                            io_master_rresp = 2'b10;
                        end
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        exp_t e;
        bit   prev_rv;
        prev_rv = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (io_master_arvalid && io_master_arready) begin
                    if (sb.size() == 0) begin
                        check("ar_unexpected", 64'd1, 64'd0);
                    end else begin
                        check("araddr",  io_master_araddr,  sb[0].addr);
                        check("arsize",  io_master_arsize,  sb[0].size);
                        check("arid",    io_master_arid,    sb[0].id);
                        check("arlen",   io_master_arlen,   64'd0);
                        check("arburst", io_master_arburst, 64'd1);
                    end
                end
                if (out_ifu_rvalid || out_lsu_rvalid) begin
                    check("rvalid_one_cycle", prev_rv, 64'd0);
                    if (sb.size() == 0) begin
                        check("rvalid_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("owner_lsu_rvalid", out_lsu_rvalid, e.lsu);
                        check("owner_ifu_rvalid", out_ifu_rvalid, !e.lsu);
                        check("rdata", e.lsu ? out_lsu_rdata : out_ifu_rdata, e.data);
                        check("rerr", out_rerr, e.err);
                    end
                end
                prev_rv = out_ifu_rvalid | out_lsu_rvalid;
            end else begin
                prev_rv = 0;
            end
        end
    end

    initial begin : global_guard
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : stim
        int t0, at, k_done;
        ifu_araddr  = '0;
        ifu_arvalid = 1'b0;
        lsu_araddr  = '0;
        lsu_arvalid = 1'b0;
        lsu_rstrb   = 8'h00;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        check("rst_arvalid", io_master_arvalid, 0);
        check("rst_rready",  io_master_rready,  0);
        check("rst_ifu_rv",  out_ifu_rvalid,    0);
        check("rst_lsu_rv",  out_lsu_rvalid,    0);
        check("rst_rerr",    out_rerr,          0);
        check("rst_timeout", out_timeout,       0);
        check("rst_arburst", io_master_arburst, 2'b01);
        check("rst_araddr",  io_master_araddr,  0);
        check("rst_arsize",  io_master_arsize,  0);
        check("rst_arid",    io_master_arid,    0);
        check("rst_arlen",   io_master_arlen,   0);
        check("rst_rdata",   out_ifu_rdata,     0);
        reset = 1'b1;
        @(negedge clock);

        // ---------------- IFU only, zero-wait slave ----------------
        t0 = cyc;
        push(0, 32'h8000_0000, 3'd2, 32'hDEAD_BEEF, 0);
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        wait_sig(2, at);
        check("t1_ar_latency", at - t0, 1);
        wait_sig(0, at);
        check("t1_done_latency", at - t0, 3);
        k_done = at;
        // keep requesting: next fetch back to back
        push(0, 32'h8000_0004, 3'd2, 32'h1234_5678, 0);
        ifu_araddr = 32'h8000_0004;
        wait_sig(2, at);
        check("t1_next_arvalid", at - k_done, 2);
        wait_sig(0, at);
        ifu_arvalid = 1'b0;
        check("t1_loop_period", at - k_done, 4);

        // ---------------- simultaneous requests from reset ----------------
        @(negedge clock); reset = 1'b0;
        repeat (2) @(negedge clock);
        sb.delete();
        reset = 1'b1;
        @(negedge clock);
        push(1, 32'h8000_1002, 3'd1, 32'h0000_BEEF, 0);
        push(0, 32'h8000_0008, 3'd2, 32'hCAFE_0001, 0);
        lsu_araddr  = 32'h8000_1002;
        lsu_rstrb   = 8'h03;
        ifu_araddr  = 32'h8000_0008;
        lsu_arvalid = 1'b1;
        ifu_arvalid = 1'b1;
        wait_sig(1, at); lsu_arvalid = 1'b0;
        wait_sig(0, at); ifu_arvalid = 1'b0;

        // second pair, with data wait and discarded non-last beats; 0xFF
        // clamps to word size at XLEN=32
        r_wait  = 2;
        r_extra = 2;
        push(1, 32'h8000_2000, 3'd2, 32'h5555_AAAA, 0);
        push(0, 32'h8000_000C, 3'd2, 32'h0BAD_F00D, 0);
        lsu_araddr  = 32'h8000_2000;
        lsu_rstrb   = 8'hFF;
        ifu_araddr  = 32'h8000_000C;
        lsu_arvalid = 1'b1;
        ifu_arvalid = 1'b1;
        wait_sig(1, at); lsu_arvalid = 1'b0;
        wait_sig(0, at); ifu_arvalid = 1'b0;
        r_wait  = 0;
        r_extra = 0;

        // ---------------- error response on a load ----------------
        push(1, 32'h8000_3004, 3'd2, 32'h7777_0000, 1);
        lsu_araddr  = 32'h8000_3004;
        lsu_rstrb   = 8'h0F;
        lsu_arvalid = 1'b1;
        wait_sig(1, at);
        lsu_arvalid = 1'b0;
        check("t4_rerr_with_lsu_rvalid", out_rerr, 1);

        // ---------------- tie after an LSU grant: IFU first ----------------
        push(0, 32'h8000_0010, 3'd2, 32'h0101_0101, 0);
        push(1, 32'h8000_3007, 3'd0, 32'h0000_00AB, 0);
        ifu_araddr  = 32'h8000_0010;
        lsu_araddr  = 32'h8000_3007;
        lsu_rstrb   = 8'h01;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        wait_sig(0, at); ifu_arvalid = 1'b0;
        wait_sig(1, at); lsu_arvalid = 1'b0;

        // ---------------- AR stall, requester drops arvalid ----------------
        ar_wait = 5;
        push(0, 32'h8000_0040, 3'd2, 32'h4040_4040, 0);
        ifu_araddr  = 32'h8000_0040;
        ifu_arvalid = 1'b1;
        wait_sig(2, at);
        ifu_arvalid = 1'b0;
        ifu_araddr  = 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t3_araddr_stable", io_master_araddr, 32'h8000_0040);
            check("t3_arvalid_held",  io_master_arvalid, 1);
        end
        wait_sig(0, at);
        ar_wait = 0;
        check("t3_no_timeout_yet", out_timeout, 0);

        // ---------------- watchdog ----------------
        r_never = 1;
        push(0, 32'h8000_0080, 3'd2, 32'h0, 0);
        ifu_araddr  = 32'h8000_0080;
        ifu_arvalid = 1'b1;
        wait_sig(3, at);
        ifu_arvalid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 7)  check("t5_timeout_early",  out_timeout, 0);
            if (i == 8)  check("t5_timeout_rise",   out_timeout, 1);
            if (i == 11) check("t5_timeout_sticky", out_timeout, 1);
            if (i == 11) check("t5_still_waiting",  io_master_rready, 1);
            @(negedge clock);
        end
        #2 reset = 1'b0;
        #1;
        check("t5_timeout_cleared", out_timeout, 0);
        check("t5_rready_cleared",  io_master_rready, 0);
        sb.delete();
        r_never = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t5_idle_arvalid", io_master_arvalid, 0);

        // ---------------- reset in DATA ----------------
        r_never = 1;
        push(0, 32'h8000_00C0, 3'd2, 32'h0, 0);
        ifu_araddr  = 32'h8000_00C0;
        ifu_arvalid = 1'b1;
        wait_sig(3, at);
        #2 reset = 1'b0;
        #1;
        check("t6_rready_async",  io_master_rready,  0);
        check("t6_arvalid_async", io_master_arvalid, 0);
        ifu_arvalid = 1'b0;
        sb.delete();
        r_never = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_no_rvalid", out_ifu_rvalid | out_lsu_rvalid, 0);
        end
        push(0, 32'h8000_0100, 3'd2, 32'hF00D_CAFE, 0);
        ifu_araddr  = 32'h8000_0100;
        ifu_arvalid = 1'b1;
        wait_sig(0, at);
        ifu_arvalid = 1'b0;

        repeat (3) @(negedge clock);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
